divider_share_arb: RTL and testbench
====================================

# divider_share_arb

Round-robin arbiter and sequencer that shares one multi-cycle iterative divider (begin-pulse / done-pulse interface, one operation in flight) between N_REQ requesters. Each requester uses a valid/ready request channel. A single response channel returns results, tagged with the requester index. The block sits between client pipelines and the divider; it owns the divider's begin strobe and captures its results.

## Interface
- WIDTH, 8: operand and result width; must match the attached divider.
- N_REQ, 4: number of requesters, 2..16.
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_cg  input  1  clock-gate enable; when low, all state holds.
- i_req_valid  input  N_REQ  per-requester request valid.
- o_req_ready  output  N_REQ  per-requester accept; at most one bit set.
- i_req_dividend  input  N_REQ*WIDTH  packed dividends; requester k occupies bits [k*WIDTH +: WIDTH].
- i_req_divisor  input  N_REQ*WIDTH  packed divisors, same packing.
- o_div_begin  output  1  single-cycle start pulse to the divider.
- o_div_dividend  output  WIDTH  registered operand to the divider.
- o_div_divisor  output  WIDTH  registered operand to the divider.
- i_div_done  input  1  single-cycle completion pulse from the divider.
- i_div_quotient  input  WIDTH  divider quotient, valid on i_div_done.
- i_div_remainder  input  WIDTH  divider remainder, valid on i_div_done.
- o_rsp_valid  output  1  response valid; held until accepted.
- i_rsp_ready  input  1  response accept.
- o_rsp_id  output  $clog2(N_REQ)  index of the requester that issued the operation.
- o_rsp_quotient  output  WIDTH  registered quotient.
- o_rsp_remainder  output  WIDTH  registered remainder.
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM has four states: IDLE, START, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any i_req_valid bit is set, the grant is the first valid index at or after rr_ptr, wrapping modulo N_REQ.
  - o_req_ready[grant] is asserted combinationally in the same cycle; the handshake completes that cycle.
  - On the handshake: register the grant's operands into o_div_dividend/o_div_divisor, register the grant index as the tag, set rr_ptr = (grant+1) mod N_REQ, and go to START.
- START: assert o_div_begin for exactly one cycle, then go to WAIT. o_div_dividend and o_div_divisor stay constant from START until the next handshake.
- WAIT: on i_div_done, capture i_div_quotient/i_div_remainder into the response registers and go to RESP. i_div_done in any other state is ignored.
- RESP:
  - o_rsp_valid=1; o_rsp_id, o_rsp_quotient and o_rsp_remainder are stable.
  - When i_rsp_ready=1, go to IDLE; no new request is accepted in that same cycle.
  - While i_rsp_ready=0, hold indefinitely; o_req_ready stays all-zero.
- o_req_ready is all-zero outside IDLE.
- Requesters may drop or change i_req_valid without having been accepted; arbitration has no memory beyond rr_ptr.
- i_cg=0 freezes FSM, rr_ptr and all registers. o_div_begin is forced low while i_cg=0.
- Asynchronous reset mid-operation returns to IDLE and discards any in-flight result. The divider must share i_rst.

## Timing
- Reset values: o_req_ready=0, o_div_begin=0, o_div_dividend=0, o_div_divisor=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_quotient=0, o_rsp_remainder=0, o_busy=0, rr_ptr=0.
- Handshake at cycle t gives o_div_begin at t+1.
- i_div_done at cycle d gives o_rsp_valid at d+1.
- Response accepted at cycle r gives IDLE at r+1; the earliest next accept is r+1.
- Total occupancy per operation = 3 + divider latency + response stall cycles.

## Configuration
- DIVIDER_SHARE_ARB_DIVZERO_BYPASS_EN defined:
  - On a handshake whose selected divisor is 0, skip START and WAIT and go directly to RESP.
  - Response is o_rsp_quotient = all-ones and o_rsp_remainder = dividend.
  - o_div_begin is not pulsed and the divider operands do not update.
  - The response appears at t+1.
- Undefined: a zero divisor is sent to the divider like any other operation, and the result is whatever the divider returns.

## Test plan
- Single request (WIDTH=8): requester 2 sends 200/7 -> one o_div_begin at t+1; after done, o_rsp_valid with id=2, quotient=28, remainder=4.
- All four requesters valid continuously with i_rsp_ready=1 -> grant order 0,1,2,3,0; exactly one o_req_ready bit set per accept.
- Backpressure: i_rsp_ready=0 for 10 cycles while requests are pending -> response values stable, o_req_ready=0 throughout, the next accept is the cycle after the response is accepted.
- Spurious i_div_done while in IDLE or RESP -> no state change and response registers unchanged.
- Divide by zero, 9/0:
  - Bypass macro defined -> response at t+1 with quotient=0xFF, remainder=9, no o_div_begin.
  - Macro undefined -> o_div_begin pulses and the divider result is passed through.
- Assert i_rst during WAIT -> all outputs zero immediately; a later i_div_done produces no response; rr_ptr=0.

Source files
------------

// File: rtl/divider_share_arb.sv
// divider_share_arb: round-robin sharing of one begin/done iterative divider among N_REQ requesters.
// Optional define DIVIDER_SHARE_ARB_DIVZERO_BYPASS_EN answers x/0 locally without starting the divider.
module divider_share_arb #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic [N_REQ-1:0]         i_req_valid,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]   i_req_dividend,
  input  logic [N_REQ*WIDTH-1:0]   i_req_divisor,
  output logic                     o_div_begin,
  output logic [WIDTH-1:0]         o_div_dividend,
  output logic [WIDTH-1:0]         o_div_divisor,
  input  logic                     i_div_done,
  input  logic [WIDTH-1:0]         i_div_quotient,
  input  logic [WIDTH-1:0]         i_div_remainder,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0] o_rsp_id,
  output logic [WIDTH-1:0]         o_rsp_quotient,
  output logic [WIDTH-1:0]         o_rsp_remainder,
  output logic                     o_busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW:0] N_L = (IDW+1)'(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next_state;

  logic [IDW-1:0]   r_rr_ptr, r_rsp_id, w_grant, w_rr_next;
  logic [IDW:0]     w_idx, w_inc;
  logic [WIDTH-1:0] r_div_dvd, r_div_dvs, r_rsp_quo, r_rsp_rem;
  logic [WIDTH-1:0] w_sel_dvd, w_sel_dvs;
  logic [WIDTH-1:0] w_dvd [N_REQ];
  logic [WIDTH-1:0] w_dvs [N_REQ];
  logic             w_found, w_hs, w_bypass;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_dvd[gi] = i_req_dividend[gi*WIDTH +: WIDTH];
      assign w_dvs[gi] = i_req_divisor[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search starts at rr_ptr and wraps, so the previous winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      if (w_idx >= N_L) w_idx = w_idx - N_L;
      if (!w_found && i_req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[IDW-1:0];
      end
    end
  end

  assign w_inc     = {1'b0, w_grant} + (IDW+1)'(1);
  assign w_rr_next = (w_inc == N_L) ? '0 : w_inc[IDW-1:0];
  assign w_sel_dvd = w_dvd[w_grant];
  assign w_sel_dvs = w_dvs[w_grant];
  assign w_hs      = i_cg && (r_state == S_IDLE) && w_found;

`ifdef DIVIDER_SHARE_ARB_DIVZERO_BYPASS_EN
  assign w_bypass = (w_sel_dvs == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_state <= S_IDLE;
    else if (i_cg) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = w_bypass ? S_RESP : S_START;
      S_START: w_next_state = S_WAIT;
      S_WAIT:  if (i_div_done) w_next_state = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready is gated by i_cg because a frozen FSM cannot complete the handshake.
  always_comb begin
    o_req_ready = '0;
    if (w_hs) o_req_ready[w_grant] = 1'b1;
    o_div_begin = (r_state == S_START) && i_cg;
    o_rsp_valid = (r_state == S_RESP);
    o_busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr  <= '0;
      r_rsp_id  <= '0;
      r_div_dvd <= '0;
      r_div_dvs <= '0;
      r_rsp_quo <= '0;
      r_rsp_rem <= '0;
    end else if (i_cg) begin
      if (w_hs) begin
        r_rr_ptr <= w_rr_next;
        r_rsp_id <= w_grant;
        if (w_bypass) begin
          r_rsp_quo <= '1;
          r_rsp_rem <= w_sel_dvd;
        end else begin
          r_div_dvd <= w_sel_dvd;
          r_div_dvs <= w_sel_dvs;
        end
      end
      if (r_state == S_WAIT && i_div_done) begin
        r_rsp_quo <= i_div_quotient;
        r_rsp_rem <= i_div_remainder;
      end
    end
  end

  assign o_div_dividend  = r_div_dvd;
  assign o_div_divisor   = r_div_dvs;
  assign o_rsp_id        = r_rsp_id;
  assign o_rsp_quotient  = r_rsp_quo;
  assign o_rsp_remainder = r_rsp_rem;

endmodule

// File: tb/tb_divider_share_arb.sv
// Bench for divider_share_arb: the bench plays the divider and checks against a round-robin/arithmetic model.
module tb_divider_share_arb;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, cg;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_dvd, req_dvs;
  logic           div_begin, div_done;
  logic [W-1:0]   div_dvd, div_dvs, div_q, div_r;
  logic           rsp_valid, rsp_ready, busy;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_q, rsp_r;

  int errors = 0;
  int checks = 0;
  int rr = 0;
  logic [W-1:0] a_tab [N];
  logic [W-1:0] b_tab [N];
  logic [W-1:0] last_opa = '0, last_opb = '0;

  always #5 clk = ~clk;

  divider_share_arb #(.WIDTH(W), .N_REQ(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_dividend(req_dvd), .i_req_divisor(req_dvs),
    .o_div_begin(div_begin), .o_div_dividend(div_dvd), .o_div_divisor(div_dvs),
    .i_div_done(div_done), .i_div_quotient(div_q), .i_div_remainder(div_r),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_quotient(rsp_q), .o_rsp_remainder(rsp_r), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops();
    for (int k = 0; k < N; k++) begin
      req_dvd[k*W +: W] = a_tab[k];
      req_dvs[k*W +: W] = b_tab[k];
    end
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) begin
      a_tab[k] = W'($urandom_range(0, 255));
      b_tab[k] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
    end
  endtask

  // First requester at or after the pointer, wrapping.
  function automatic int model_grant(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  task automatic run_op(input logic [N-1:0] mask, input int lat, input int stall,
                        input int cgs, input bit spur, output int g);
    logic [W-1:0] a, b, eq, er;
    bit byp;
    set_ops();
    req_valid = mask;
    #1;
    g = model_grant(mask);
    chk("ready_onehot", 32'(req_ready), 32'(1 << g));
    chk("idle_not_busy", 32'(busy), 0);
    a = a_tab[g];
    b = b_tab[g];
    byp = 1'b0;
`ifdef DIVIDER_SHARE_ARB_DIVZERO_BYPASS_EN
    byp = (b == '0);
`endif
    step();
    rr = (g + 1) % N;
    if (byp) begin
      eq = '1;
      er = a;
      chk("bypass_no_begin", 32'(div_begin), 0);
      chk("bypass_op_hold", 32'(div_dvd), 32'(last_opa));
      chk("bypass_opb_hold", 32'(div_dvs), 32'(last_opb));
    end else begin
      if (cgs > 0) begin
        cg = 1'b0;
        #1;
        chk("cg_begin_low", 32'(div_begin), 0);
        repeat (cgs) begin
          step();
          chk("cg_hold_busy", 32'(busy), 1);
          chk("cg_begin_low", 32'(div_begin), 0);
        end
        cg = 1'b1;
        #1;
      end
      chk("begin_pulse", 32'(div_begin), 1);
      chk("op_dividend", 32'(div_dvd), 32'(a));
      chk("op_divisor", 32'(div_dvs), 32'(b));
      chk("busy_ready_low", 32'(req_ready), 0);
      last_opa = a;
      last_opb = b;
      step();
      repeat (lat - 1) begin
        chk("begin_once", 32'(div_begin), 0);
        step();
      end
      chk("begin_once", 32'(div_begin), 0);
      if (b != '0) begin
        eq = a / b;
        er = a % b;
      end else begin
        eq = 8'hA5;
        er = 8'h5A;
      end
      div_done = 1'b1; div_q = eq; div_r = er;
      step();
      div_done = 1'b0; div_q = W'($urandom); div_r = W'($urandom);
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_quotient", 32'(rsp_q), 32'(eq));
    chk("rsp_remainder", 32'(rsp_r), 32'(er));
    rsp_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (spur && s == 0) begin
        div_done = 1'b1; div_q = W'($urandom); div_r = W'($urandom);
      end
      step();
      div_done = 1'b0;
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_quotient", 32'(rsp_q), 32'(eq));
      chk("stall_remainder", 32'(rsp_r), 32'(er));
      chk("stall_ready_low", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("accept_cycle_ready_low", 32'(req_ready), 0);
    step();
    rsp_ready = 1'b0;
    chk("back_to_idle", 32'(busy), 0);
    chk("next_accept_ready", 32'(req_ready), 32'(1 << model_grant(mask)));
    req_valid = '0;
    $display("op grant=%0d a=%0d b=%0d q=%0d r=%0d lat=%0d stall=%0d", g, a, b, eq, er, lat, stall);
  endtask

  initial begin
    int g;
    rst = 1'b1; cg = 1'b1; req_valid = '0; req_dvd = '0; req_dvs = '0;
    div_done = 1'b0; div_q = '0; div_r = '0; rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin a_tab[k] = '0; b_tab[k] = '0; end
    step();
    step();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_begin", 32'(div_begin), 0);
    chk("rst_dvd", 32'(div_dvd), 0);
    chk("rst_dvs", 32'(div_dvs), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_q", 32'(rsp_q), 0);
    chk("rst_rsp_r", 32'(rsp_r), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    // Spurious done in IDLE.
    div_done = 1'b1; div_q = 8'h33; div_r = 8'h44;
    step();
    div_done = 1'b0;
    chk("spur_idle_busy", 32'(busy), 0);
    chk("spur_idle_valid", 32'(rsp_valid), 0);
    chk("spur_idle_q", 32'(rsp_q), 0);
    $display("spurious done in idle");

    // Requester 2: 200/7.
    rand_ops();
    a_tab[2] = 8'd200; b_tab[2] = 8'd7;
    run_op(4'b0100, 3, 0, 0, 1'b0, g);
    chk("directed_q", 32'(dut.o_rsp_quotient), 28);

    // Reset while waiting on the divider.
    rand_ops();
    b_tab[1] = 8'd5;
    set_ops();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_begin", 32'(div_begin), 0);
    chk("arst_dvd", 32'(div_dvd), 0);
    chk("arst_dvs", 32'(div_dvs), 0);
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_id", 32'(rsp_id), 0);
    chk("arst_q", 32'(rsp_q), 0);
    chk("arst_r", 32'(rsp_r), 0);
    chk("arst_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    div_done = 1'b1; div_q = 8'h77; div_r = 8'h11;
    step();
    div_done = 1'b0;
    chk("late_done_valid", 32'(rsp_valid), 0);
    chk("late_done_busy", 32'(busy), 0);
    rr = 0; last_opa = '0; last_opb = '0;
    $display("reset during wait");

    // All four requesters continuously valid.
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      run_op(4'hF, $urandom_range(1, 4), 0, 0, 1'b0, g);
      chk("rr_order", 32'(g), 32'(i % N));
    end

    // Backpressure with a spurious done during RESP.
    rand_ops();
    run_op(4'hF, 2, 10, 0, 1'b1, g);

    // Clock-gate hold in START.
    rand_ops();
    run_op(4'b0110, 2, 1, 3, 1'b0, g);

    // 9/0 from requester 3.
    rand_ops();
    a_tab[3] = 8'd9; b_tab[3] = '0;
    run_op(4'b1000, 2, 1, 0, 1'b0, g);
    chk("div0_id", 32'(g), 3);

    for (int i = 0; i < 20; i++) begin
      rand_ops();
      run_op(N'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(0, 3),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
